// File: rtl/spi_xfer_scheduler_if.sv
// APB bus between the transfer scheduler (master) and the Gray converter (slave).
interface spi_xfer_scheduler_if;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/spi_xfer_scheduler.sv
// Round-robin APB master: for each grant writes the operand, issues the start command,
// waits for the SPI exchange, reads back the Gray result and acks the served client.
module spi_xfer_scheduler #(
  parameter logic [7:0] XFER_WAIT      = 8'd20,
  parameter logic [7:0] PREADY_TIMEOUT = 8'd15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req,
  input  logic [7:0]                  req_data0,
  input  logic [7:0]                  req_data1,
  output logic [1:0]                  ack,
  output logic [7:0]                  rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  spi_xfer_scheduler_if.master        apb
);

  typedef enum logic [3:0] {
    StIdle, StOpSetup, StOpAccess, StGap, StCtlSetup, StCtlAccess,
    StWaitSpi, StRdSetup, StRdAccess, StDone
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       grant_id_q;
  logic       last_grant_q;
  logic [2:0] paddr_q;
  logic [7:0] pwdata_q;
  logic       pwrite_q;
  logic       psel_q;
  logic       penable_q;
  logic       winner;
  logic [1:0] ack_grant;

  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;

  // With both requesting, the client not served last wins; a lone requester always wins.
  always_comb begin
    winner    = (req == 2'b11) ? ~last_grant_q : req[1];
    ack_grant = grant_id_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      ack          <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            grant_id_q   <= winner;
            last_grant_q <= winner;
            busy         <= 1'b1;
            psel_q       <= 1'b1;
            penable_q    <= 1'b0;
            paddr_q      <= 3'd0;
            pwrite_q     <= 1'b1;
            pwdata_q     <= winner ? req_data1 : req_data0;
            state_q      <= StOpSetup;
          end
        end
        StOpSetup, StCtlSetup, StRdSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= (state_q == StOpSetup)  ? StOpAccess :
                       (state_q == StCtlSetup) ? StCtlAccess : StRdAccess;
        end
        StOpAccess, StCtlAccess, StRdAccess: begin
          if (apb.pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            if (apb.pslverr) begin
              ack      <= ack_grant;
              rsp_data <= 8'h00;
              rsp_err  <= 1'b1;
              state_q  <= StDone;
            end else if (state_q == StOpAccess) begin
              state_q <= StGap;
            end else if (state_q == StCtlAccess) begin
              state_q <= StWaitSpi;
            end else begin
              ack      <= ack_grant;
              rsp_data <= apb.prdata;
              rsp_err  <= 1'b0;
              state_q  <= StDone;
            end
          end else if (cnt_q == PREADY_TIMEOUT - 8'd1) begin
            // Slave never answered: abandon the whole service with an error.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            ack       <= ack_grant;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
          psel_q   <= 1'b1;
          paddr_q  <= 3'd4;
          pwrite_q <= 1'b1;
          pwdata_q <= 8'h01;
          state_q  <= StCtlSetup;
        end
        StWaitSpi: begin
          if (cnt_q == XFER_WAIT - 8'd1) begin
            cnt_q    <= '0;
            psel_q   <= 1'b1;
            paddr_q  <= 3'd2;
            pwrite_q <= 1'b0;
            state_q  <= StRdSetup;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          ack     <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Randomized scoreboard bench for spi_xfer_scheduler against a Gray-converter slave model.
module tb_spi_xfer_scheduler;
  localparam logic [7:0] XW = 8'd20;
  localparam logic [7:0] TO = 8'd15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] d0, d1;
  logic [1:0] ack;
  logic [7:0] rsp_data;
  logic       rsp_err, busy;

  spi_xfer_scheduler_if apb ();

  spi_xfer_scheduler #(.XFER_WAIT(XW), .PREADY_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data0(d0), .req_data1(d1),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .apb(apb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Slave: 0 = normal, 1 = pslverr at err_addr, 2 = pready stuck low
  int         mode = 0;
  logic [2:0] err_addr = 3'd0;
  logic [7:0] op_reg = 8'h00;
  typedef struct packed {logic wr; logic [2:0] addr; logic [7:0] data;} xfer_t;
  xfer_t log_q[$];

  assign apb.pready  = apb.psel && apb.penable && (mode != 2);
  assign apb.pslverr = (mode == 1) && (apb.paddr == err_addr);
  assign apb.prdata  = (apb.paddr == 3'd2) ? gray(op_reg) : 8'h00;

  always @(posedge clk) begin
    if (apb.psel && apb.penable && apb.pready) begin
      log_q.push_back({apb.pwrite, apb.paddr, apb.pwrite ? apb.pwdata : apb.prdata});
      if (apb.pwrite && apb.paddr == 3'd0 && !apb.pslverr) op_reg <= apb.pwdata;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  // Reference model: round-robin order and Gray result per service
  typedef struct packed {logic [1:0] ack; logic [7:0] data; logic err;} exp_t;
  exp_t exp_q[$];
  logic last_grant_m;

  task automatic push_exp(input logic id, input logic [7:0] data, input logic err);
    exp_t e;
    e.ack  = id ? 2'b10 : 2'b01;
    e.data = err ? 8'h00 : gray(data);
    e.err  = err;
    exp_q.push_back(e);
    last_grant_m = id;
  endtask

  task automatic model_round(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b,
                             input logic err);
    logic first;
    if (r == 2'b11) begin
      first = ~last_grant_m;
      push_exp(first, first ? b : a, err);
      push_exp(~first, first ? a : b, err);
    end else begin
      push_exp(r[1], r[1] ? b : a, err);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: got ack=%b, required no ack", ack);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ack", 32'(ack), 32'(e.ack));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    last_grant_m = 1'b1;
    exp_q.delete();
  endtask

  // Hold each request until its ack, dropping it on the ack cycle.
  task automatic run_service(input logic [1:0] r, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    d0  = a;
    d1  = b;
    req = r;
    for (int c = 0; c < 300 && req != 2'b00; c++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    if (req != 2'b00) begin
      n_vec++;
      n_err++;
      $display("FAIL service_timeout: req=%b still pending, required all acked", req);
      mode = 0;
      do_reset();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    xfer_t want_log[3];
    int    lat, pen;
    logic  seen;
    logic [1:0] r;
    logic [7:0] a, b;
    int    m;

    rst_n = 1'b0;
    req   = 2'b00;
    d0    = 8'h00;
    d1    = 8'h00;
    last_grant_m = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_psel", 32'(apb.psel), 0);
    check("rst_penable", 32'(apb.penable), 0);
    check("rst_pwrite", 32'(apb.pwrite), 0);
    check("rst_paddr", 32'(apb.paddr), 0);
    check("rst_pwdata", 32'(apb.pwdata), 0);
    check("rst_rsp", 32'({rsp_err, rsp_data}), 0);
    rst_n = 1'b1;

    // Single request: latency and bus sequence
    log_q.delete();
    model_round(2'b01, 8'hB4, 8'h00, 1'b0);
    @(negedge clk);
    d0  = 8'hB4;
    req = 2'b01;
    lat = 0;
    while (ack == 2'b00 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    req = 2'b00;
    check("latency", 32'(lat), 32'(8 + int'(XW)));
    want_log[0] = {1'b1, 3'd0, 8'hB4};
    want_log[1] = {1'b1, 3'd4, 8'h01};
    want_log[2] = {1'b0, 3'd2, 8'hEE};
    check("xfer_count", 32'(log_q.size()), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("xfer%0d", i), (i < log_q.size()) ? 32'(log_q[i]) : 32'hFFFF_FFFF,
            32'(want_log[i]));

    // Simultaneous requests after reset, then both again
    do_reset();
    model_round(2'b11, 8'h01, 8'hFF, 1'b0);
    run_service(2'b11, 8'h01, 8'hFF);
    model_round(2'b11, 8'h3C, 8'hA5, 1'b0);
    run_service(2'b11, 8'h3C, 8'hA5);

    // Continuous req=11 for four services
    for (int i = 0; i < 4; i++) push_exp(~last_grant_m, last_grant_m ? 8'h5A : 8'hC3, 1'b0);
    @(negedge clk);
    d0  = 8'h5A;
    d1  = 8'hC3;
    req = 2'b11;
    pen = 0;
    for (int c = 0; c < 400 && pen < 4; c++) begin
      @(negedge clk);
      if (ack != 2'b00) pen++;
    end
    req = 2'b00;
    check("rr_acks", 32'(pen), 4);

    // Slave error on the operand write
    mode     = 1;
    err_addr = 3'd0;
    log_q.delete();
    model_round(2'b01, 8'h77, 8'h00, 1'b1);
    run_service(2'b01, 8'h77, 8'h00);
    check("err_xfer_count", 32'(log_q.size()), 1);
    mode = 0;

    // pready stuck low
    mode = 2;
    model_round(2'b01, 8'h12, 8'h00, 1'b1);
    @(negedge clk);
    d0   = 8'h12;
    req  = 2'b01;
    pen  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (apb.penable) pen++;
      if (ack != 2'b00) seen = 1'b1;
    end
    req = 2'b00;
    check("timeout_ack_seen", 32'(seen), 1);
    check("penable_cycles", 32'(pen), 32'(TO));
    @(negedge clk);
    check("busy_after_ack", 32'(busy), 0);
    mode = 0;

    // Reset in the middle of the SPI wait
    @(negedge clk);
    d0  = 8'h99;
    req = 2'b01;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_psel", 32'(apb.psel), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ack", 32'(ack), 0);
    req   = 2'b00;
    rst_n = 1'b1;
    last_grant_m = 1'b1;
    repeat (40) @(negedge clk);
    model_round(2'b11, 8'h0F, 8'hF0, 1'b0);
    run_service(2'b11, 8'h0F, 8'hF0);

    // Randomized rounds
    for (int i = 0; i < 40; i++) begin
      r = 2'($urandom_range(1, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      m = $urandom_range(0, 9);
      if (m < 7) begin
        mode = 0;
      end else if (m < 9) begin
        mode = 1;
        err_addr = (m == 7) ? 3'd0 : (($urandom & 1) != 0 ? 3'd4 : 3'd2);
      end else begin
        mode = 2;
      end
      model_round(r, a, b, mode != 0);
      run_service(r, a, b);
      mode = 0;
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
